// File: rtl/program_mem_pkg.sv
// Shared types for the program-memory read controller: per-channel state
// encoding and the owner-index width helper.
package program_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    WAITING  = 2'b01,
    RELAYING = 2'b10
  } channel_state_e;

  // Width of a consumer index; a single consumer still needs one bit.
  function automatic int owner_width(input int num_consumers);
    return (num_consumers > 1) ? $clog2(num_consumers) : 1;
  endfunction

endpackage

// File: rtl/mem_req_picker.sv
// Lowest-index set-bit finder used by each channel to pick the next
// fetcher to serve from its masked candidate vector.
module mem_req_picker #(
  parameter int NUM_BITS   = 4,
  parameter int INDEX_BITS = 2
) (
  input  logic [NUM_BITS-1:0]   candidates,
  output logic                  found,
  output logic [INDEX_BITS-1:0] index
);

  // NOTE: combinational logic uses blocking assignments with a default first,
  // so every path assigns every output and no latch is inferred.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = NUM_BITS - 1; i >= 0; i--) begin
      if (candidates[i]) begin
        found = 1'b1;
        index = INDEX_BITS'(i);
      end
    end
  end

endmodule

// File: rtl/program_mem_controller.sv
// Multiplexes fetcher read requests onto the external program-memory read
// channels and relays each instruction word back to its requester.
module program_mem_controller
  import program_mem_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_CONSUMERS-1:0]                  consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]   consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                  consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]   consumer_read_data,
  output logic [NUM_CHANNELS-1:0]                   mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]    mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                   mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]    mem_read_data
);

  localparam int OW = owner_width(NUM_CONSUMERS);

  channel_state_e             chan_state [NUM_CHANNELS];
  logic [OW-1:0]              owner      [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]   claim;

  logic [NUM_CONSUMERS-1:0]   avail       [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0]   pick_onehot [NUM_CHANNELS];
  logic [OW-1:0]              pick_index  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]    pick_found;
  logic [NUM_CHANNELS-1:0]    release_ch;
  logic [NUM_CONSUMERS-1:0]   grant_mask;
  logic [NUM_CONSUMERS-1:0]   release_mask;

  // Lower channels pick first; each pick is removed before the next channel looks.
  assign avail[0] = consumer_read_valid & ~claim;

  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
    logic [NUM_CONSUMERS-1:0] candidates;

    assign candidates = (chan_state[ch] == IDLE) ? avail[ch] : '0;

    mem_req_picker #(
      .NUM_BITS   (NUM_CONSUMERS),
      .INDEX_BITS (OW)
    ) u_picker (
      .candidates (candidates),
      .found      (pick_found[ch]),
      .index      (pick_index[ch])
    );

    assign pick_onehot[ch] = pick_found[ch] ? (NUM_CONSUMERS'(1) << pick_index[ch]) : '0;
    assign release_ch[ch]  = (chan_state[ch] == RELAYING) && !consumer_read_valid[owner[ch]];

    if (ch + 1 < NUM_CHANNELS) begin : g_next
      assign avail[ch+1] = avail[ch] & ~pick_onehot[ch];
    end
  end

  always_comb begin
    grant_mask   = '0;
    release_mask = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      grant_mask = grant_mask | pick_onehot[ch];
      if (release_ch[ch]) release_mask[owner[ch]] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        chan_state[ch] <= IDLE;
        owner[ch]      <= '0;
      end
      claim               <= '0;
      mem_read_valid      <= '0;
      mem_read_address    <= '0;
      consumer_read_ready <= '0;
      consumer_read_data  <= '0;
    end else begin
      // A releasing consumer is still claimed this cycle, so it cannot be re-granted yet.
      claim <= (claim & ~release_mask) | grant_mask;
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        case (chan_state[ch])
          IDLE: begin
            if (pick_found[ch]) begin
              owner[ch]            <= pick_index[ch];
              mem_read_valid[ch]   <= 1'b1;
              mem_read_address[ch] <= consumer_read_address[pick_index[ch]];
              chan_state[ch]       <= WAITING;
            end
          end
          WAITING: begin
            if (mem_read_ready[ch]) begin
              consumer_read_data[owner[ch]]  <= mem_read_data[ch];
              consumer_read_ready[owner[ch]] <= 1'b1;
              mem_read_valid[ch]             <= 1'b0;
              chan_state[ch]                 <= RELAYING;
            end
          end
          RELAYING: begin
            if (release_ch[ch]) begin
              consumer_read_ready[owner[ch]] <= 1'b0;
              chan_state[ch]                 <= IDLE;
            end
          end
          default: chan_state[ch] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_program_mem_controller.sv
// Self-checking bench: a 1-channel and a 2-channel controller driven by
// directed scenarios and random fetcher traffic against a behavioural model.
module tb_program_mem_controller;

  logic clk = 1'b0;
  logic reset;

  logic [3:0]        a_valid, a_ready;
  logic [3:0][7:0]   a_addr;
  logic [3:0][15:0]  a_data;
  logic [0:0]        a_mvalid, a_mready;
  logic [0:0][7:0]   a_maddr;
  logic [0:0][15:0]  a_mdata;

  logic [3:0]        b_valid, b_ready;
  logic [3:0][7:0]   b_addr;
  logic [3:0][15:0]  b_data;
  logic [1:0]        b_mvalid, b_mready;
  logic [1:0][7:0]   b_maddr;
  logic [1:0][15:0]  b_mdata;

  logic [15:0] mem [256];
  int errors = 0;
  int checks = 0;
  bit resp_on = 0;
  int fixed_lat = 0;

  always #5 clk = ~clk;

  program_mem_controller #(
    .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)
  ) dut_a (
    .clk(clk), .reset(reset),
    .consumer_read_valid(a_valid), .consumer_read_address(a_addr),
    .consumer_read_ready(a_ready), .consumer_read_data(a_data),
    .mem_read_valid(a_mvalid), .mem_read_address(a_maddr),
    .mem_read_ready(a_mready), .mem_read_data(a_mdata)
  );

  program_mem_controller #(
    .ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)
  ) dut_b (
    .clk(clk), .reset(reset),
    .consumer_read_valid(b_valid), .consumer_read_address(b_addr),
    .consumer_read_ready(b_ready), .consumer_read_data(b_data),
    .mem_read_valid(b_mvalid), .mem_read_address(b_maddr),
    .mem_read_ready(b_mready), .mem_read_data(b_mdata)
  );

  // External memory: answers each request after a latency, one-cycle strobe.
  initial begin
    int a_cnt, a_lat;
    int b_cnt [2];
    int b_lat [2];
    a_cnt = 0; a_lat = 1; b_cnt = '{0, 0}; b_lat = '{1, 1};
    forever begin
      @(negedge clk);
      if (!resp_on) begin
        a_cnt = 0; b_cnt = '{0, 0};
      end else begin
        if (a_mready[0]) begin
          a_mready[0] = 1'b0; a_cnt = 0;
        end else if (a_mvalid[0]) begin
          if (a_cnt == 0) a_lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
          a_cnt++;
          if (a_cnt >= a_lat) begin
            a_mready[0] = 1'b1; a_mdata[0] = mem[a_maddr[0]];
          end
        end
        for (int ch = 0; ch < 2; ch++) begin
          if (b_mready[ch]) begin
            b_mready[ch] = 1'b0; b_cnt[ch] = 0;
          end else if (b_mvalid[ch]) begin
            if (b_cnt[ch] == 0) b_lat[ch] = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
            b_cnt[ch]++;
            if (b_cnt[ch] >= b_lat[ch]) begin
              b_mready[ch] = 1'b1; b_mdata[ch] = mem[b_maddr[ch]];
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resp_on = 0; fixed_lat = 0;
    a_valid = '0; a_addr = '0; a_mready = '0; a_mdata = '0;
    b_valid = '0; b_addr = '0; b_mready = '0; b_mdata = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (a_ready !== 4'b0) begin errors++; $display("FAIL reset_a_ready: got %b expected 0000", a_ready); end
    checks++; if (a_data !== '0) begin errors++; $display("FAIL reset_a_data: got %h expected 0", a_data); end
    checks++; if (a_mvalid !== 1'b0) begin errors++; $display("FAIL reset_a_mvalid: got %b expected 0", a_mvalid); end
    checks++; if (a_maddr !== '0) begin errors++; $display("FAIL reset_a_maddr: got %h expected 0", a_maddr); end
    checks++; if (b_ready !== 4'b0) begin errors++; $display("FAIL reset_b_ready: got %b expected 0000", b_ready); end
    checks++; if (b_data !== '0) begin errors++; $display("FAIL reset_b_data: got %h expected 0", b_data); end
    checks++; if (b_mvalid !== 2'b0) begin errors++; $display("FAIL reset_b_mvalid: got %b expected 00", b_mvalid); end
    checks++; if (b_maddr !== '0) begin errors++; $display("FAIL reset_b_maddr: got %h expected 0", b_maddr); end
  endtask

  task automatic test_single_fetch();
    int k;
    bit seen;
    apply_reset();
    fixed_lat = 3; resp_on = 1;
    a_addr[0] = 8'h05; a_valid[0] = 1'b1;
    tick();
    checks++;
    if (a_mvalid !== 1'b1 || a_maddr[0] !== 8'h05) begin
      errors++; $display("FAIL single_issue: mvalid=%b addr=%h expected 1 05", a_mvalid, a_maddr[0]);
    end
    k = 0; seen = 0;
    while (!seen && k < 20) begin
      if (a_mready[0]) begin
        seen = 1;
        checks++;
        if (a_ready !== 4'b0001 || a_data[0] !== 16'hA1B2 || k != 3) begin
          errors++; $display("FAIL single_return: ready=%b data=%h after %0d cycles expected 0001 a1b2 after 3", a_ready, a_data[0], k);
        end
      end else begin
        checks++;
        if (a_ready !== 4'b0 || a_mvalid !== 1'b1 || a_maddr[0] !== 8'h05) begin
          errors++; $display("FAIL single_wait: ready=%b mvalid=%b addr=%h expected 0000 1 05", a_ready, a_mvalid, a_maddr[0]);
        end
        tick(); k++;
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL single_timeout: no memory response within 20 cycles"); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (a_ready !== 4'b0001) begin errors++; $display("FAIL single_hold: ready=%b expected 0001", a_ready); end
    end
    a_valid[0] = 1'b0;
    tick();
    checks++;
    if (a_ready !== 4'b0 || a_data[0] !== 16'hA1B2 || a_mvalid !== 1'b0) begin
      errors++; $display("FAIL single_release: ready=%b data=%h mvalid=%b expected 0000 a1b2 0", a_ready, a_data[0], a_mvalid);
    end
  endtask

  task automatic test_in_order();
    int n;
    logic [3:0] prev;
    apply_reset();
    resp_on = 1;
    for (int c = 0; c < 4; c++) a_addr[c] = 8'h10 + 8'(c);
    a_valid = 4'hF;
    n = 0; prev = '0;
    tick();
    for (int cyc = 0; cyc < 200 && n < 4; cyc++) begin
      checks++; if ($countones(a_ready) > 1) begin errors++; $display("FAIL order_overlap: ready=%b expected at most one bit", a_ready); end
      for (int c = 0; c < 4; c++) begin
        if (a_ready[c] && !prev[c]) begin
          checks++;
          if (c != n || a_data[c] !== mem[8'h10 + c]) begin
            errors++; $display("FAIL order_serve: consumer %0d data=%h expected consumer %0d data=%h", c, a_data[c], n, mem[8'h10 + n]);
          end
          n++;
          a_valid[c] = 1'b0;
        end
      end
      prev = a_ready;
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL order_timeout: served %0d expected 4", n); end
    checks++; if (a_ready !== 4'b0) begin errors++; $display("FAIL order_final: ready=%b expected 0000", a_ready); end
  endtask

  task automatic test_two_channels();
    int n, cyc;
    int rise_t [4];
    bit second_checked;
    logic [3:0] prev;
    apply_reset();
    fixed_lat = 2; resp_on = 1;
    for (int c = 0; c < 4; c++) b_addr[c] = 8'h20 + 8'(c);
    b_valid = 4'hF;
    tick();
    checks++;
    if (b_mvalid !== 2'b11 || b_maddr[0] !== 8'h20 || b_maddr[1] !== 8'h21) begin
      errors++; $display("FAIL dual_first_alloc: mvalid=%b addr0=%h addr1=%h expected 11 20 21", b_mvalid, b_maddr[0], b_maddr[1]);
    end
    n = 0; prev = '0; second_checked = 0; rise_t = '{0, 0, 0, 0};
    for (cyc = 0; cyc < 200 && n < 4; cyc++) begin
      if (n >= 2 && !second_checked && b_mvalid !== 2'b00) begin
        second_checked = 1;
        checks++;
        if (b_mvalid !== 2'b11 || b_maddr[0] !== 8'h22 || b_maddr[1] !== 8'h23) begin
          errors++; $display("FAIL dual_second_alloc: mvalid=%b addr0=%h addr1=%h expected 11 22 23", b_mvalid, b_maddr[0], b_maddr[1]);
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (b_ready[c] && !prev[c]) begin
          checks++;
          if (c != n || b_data[c] !== mem[8'h20 + c]) begin
            errors++; $display("FAIL dual_serve: consumer %0d data=%h expected consumer %0d data=%h", c, b_data[c], n, mem[8'h20 + n]);
          end
          rise_t[c] = cyc; n++;
          b_valid[c] = 1'b0;
        end
      end
      prev = b_ready;
      tick();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL dual_timeout: served %0d expected 4", n); end
    checks++;
    if (rise_t[0] != rise_t[1] || rise_t[2] != rise_t[3] || rise_t[2] <= rise_t[1]) begin
      errors++; $display("FAIL dual_pairing: ready cycles %0d %0d %0d %0d expected pairs 0/1 then 2/3", rise_t[0], rise_t[1], rise_t[2], rise_t[3]);
    end
  endtask

  task automatic test_rerequest();
    bit got;
    apply_reset();
    fixed_lat = 1; resp_on = 1;
    a_addr[2] = 8'h30; a_valid[2] = 1'b1;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin tick(); if (a_ready[2]) got = 1; end
    checks++;
    if (!got || a_ready !== 4'b0100 || a_data[2] !== mem[8'h30]) begin
      errors++; $display("FAIL rereq_first: ready=%b data=%h expected 0100 %h", a_ready, a_data[2], mem[8'h30]);
    end
    a_valid[2] = 1'b0;
    tick();
    checks++;
    if (a_ready !== 4'b0 || a_mvalid !== 1'b0) begin
      errors++; $display("FAIL rereq_release: ready=%b mvalid=%b expected 0000 0", a_ready, a_mvalid);
    end
    a_addr[2] = 8'h31; a_valid[2] = 1'b1;
    tick();
    checks++;
    if (a_mvalid !== 1'b1 || a_maddr[0] !== 8'h31) begin
      errors++; $display("FAIL rereq_reclaim: mvalid=%b addr=%h expected 1 31", a_mvalid, a_maddr[0]);
    end
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin tick(); if (a_ready[2]) got = 1; end
    checks++;
    if (!got || a_ready !== 4'b0100 || a_data[2] !== mem[8'h31]) begin
      errors++; $display("FAIL rereq_second: ready=%b data=%h expected 0100 %h", a_ready, a_data[2], mem[8'h31]);
    end
  endtask

  task automatic test_reset_mid_wait();
    apply_reset();
    a_addr[1] = 8'h44; a_valid[1] = 1'b1;
    tick();
    checks++;
    if (a_mvalid !== 1'b1 || a_maddr[0] !== 8'h44) begin
      errors++; $display("FAIL rst_wait_issue: mvalid=%b addr=%h expected 1 44", a_mvalid, a_maddr[0]);
    end
    tick();
    reset = 1'b1; a_valid[1] = 1'b0;
    tick();
    checks++;
    if (a_ready !== 4'b0 || a_data !== '0 || a_mvalid !== 1'b0 || a_maddr !== '0) begin
      errors++; $display("FAIL rst_wait_clear: ready=%b data=%h mvalid=%b addr=%h expected all 0", a_ready, a_data, a_mvalid, a_maddr);
    end
    reset = 1'b0; a_mready[0] = 1'b1; a_mdata[0] = 16'hDEAD;
    tick();
    checks++;
    if (a_ready !== 4'b0 || a_data !== '0 || a_mvalid !== 1'b0 || a_maddr !== '0) begin
      errors++; $display("FAIL rst_late_resp: ready=%b data=%h mvalid=%b addr=%h expected all 0", a_ready, a_data, a_mvalid, a_maddr);
    end
    a_mready[0] = 1'b0;
    tick();
    checks++; if (a_ready !== 4'b0) begin errors++; $display("FAIL rst_late_ready: ready=%b expected 0000", a_ready); end
    a_addr[1] = 8'h45; a_valid[1] = 1'b1;
    tick();
    checks++;
    if (a_mvalid !== 1'b1 || a_maddr[0] !== 8'h45) begin
      errors++; $display("FAIL rst_claim_empty: mvalid=%b addr=%h expected 1 45", a_mvalid, a_maddr[0]);
    end
  endtask

  task automatic test_spurious_ready();
    apply_reset();
    a_mready[0] = 1'b1; a_mdata[0] = 16'hBEEF;
    tick(); tick();
    checks++;
    if (a_ready !== 4'b0 || a_data !== '0 || a_mvalid !== 1'b0) begin
      errors++; $display("FAIL spur_idle: ready=%b data=%h mvalid=%b expected all 0", a_ready, a_data, a_mvalid);
    end
    a_mready[0] = 1'b0;
    a_addr[0] = 8'h40; a_valid[0] = 1'b1;
    tick();
    checks++; if (a_mvalid !== 1'b1) begin errors++; $display("FAIL spur_issue: mvalid=%b expected 1", a_mvalid); end
    a_mready[0] = 1'b1; a_mdata[0] = mem[8'h40];
    tick();
    checks++;
    if (a_ready !== 4'b0001 || a_data[0] !== mem[8'h40] || a_mvalid !== 1'b0) begin
      errors++; $display("FAIL spur_serve: ready=%b data=%h mvalid=%b expected 0001 %h 0", a_ready, a_data[0], a_mvalid, mem[8'h40]);
    end
    a_mdata[0] = 16'hBEEF;
    tick();
    checks++;
    if (a_ready !== 4'b0001 || a_data[0] !== mem[8'h40]) begin
      errors++; $display("FAIL spur_relaying: ready=%b data=%h expected 0001 %h", a_ready, a_data[0], mem[8'h40]);
    end
    a_mready[0] = 1'b0; a_valid[0] = 1'b0;
    tick();
    checks++;
    if (a_ready !== 4'b0 || a_data[0] !== mem[8'h40]) begin
      errors++; $display("FAIL spur_release: ready=%b data=%h expected 0000 %h", a_ready, a_data[0], mem[8'h40]);
    end
  endtask

  // Fetcher model: 0 idle, 1 requesting, 2 served and holding, 3 just dropped.
  task automatic test_random_traffic();
    int phase [4];
    int hold [4];
    int wait_cnt [4];
    logic [7:0] raddr [4];
    bit ok;
    apply_reset();
    resp_on = 1;
    phase = '{0, 0, 0, 0}; hold = '{0, 0, 0, 0}; wait_cnt = '{0, 0, 0, 0};
    raddr = '{8'h0, 8'h0, 8'h0, 8'h0};
    for (int cyc = 0; cyc < 460; cyc++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (b_mvalid[ch]) begin
          ok = 0;
          for (int c = 0; c < 4; c++) if (phase[c] == 1 && raddr[c] == b_maddr[ch]) ok = 1;
          checks++;
          if (!ok) begin errors++; $display("FAIL rand_chan_addr: channel %0d addr=%h matches no pending request", ch, b_maddr[ch]); end
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (phase[c] == 1) begin
          if (b_ready[c]) begin
            checks++;
            if (b_data[c] !== mem[raddr[c]]) begin
              errors++; $display("FAIL rand_data: consumer %0d data=%h expected %h", c, b_data[c], mem[raddr[c]]);
            end
            hold[c] = $urandom_range(0, 2);
            if (hold[c] == 0) begin b_valid[c] = 1'b0; phase[c] = 3; end
            else phase[c] = 2;
          end else begin
            wait_cnt[c]++;
            checks++;
            if (wait_cnt[c] == 60) begin errors++; $display("FAIL rand_starve: consumer %0d waited 60 cycles", c); end
          end
        end else if (phase[c] == 2) begin
          checks++;
          if (b_ready[c] !== 1'b1) begin errors++; $display("FAIL rand_hold: consumer %0d ready=%b expected 1", c, b_ready[c]); end
          hold[c]--;
          if (hold[c] == 0) begin b_valid[c] = 1'b0; phase[c] = 3; end
        end else begin
          checks++;
          if (b_ready[c] !== 1'b0 || (phase[c] == 3 && b_data[c] !== mem[raddr[c]])) begin
            errors++; $display("FAIL rand_idle: consumer %0d ready=%b data=%h expected 0 %h", c, b_ready[c], b_data[c], mem[raddr[c]]);
          end
          phase[c] = 0;
          if (cyc < 340 && $urandom_range(0, 2) == 0) begin
            raddr[c] = 8'($urandom);
            b_addr[c] = raddr[c]; b_valid[c] = 1'b1;
            phase[c] = 1; wait_cnt[c] = 0;
          end
        end
      end
      tick();
    end
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (phase[c] != 0 || b_ready[c] !== 1'b0) begin
        errors++; $display("FAIL rand_drain: consumer %0d phase=%0d ready=%b expected idle", c, phase[c], b_ready[c]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[8'h05] = 16'hA1B2;
    mem[8'h40] = 16'h1357;
    reset = 1'b1;
    a_valid = '0; a_addr = '0; a_mready = '0; a_mdata = '0;
    b_valid = '0; b_addr = '0; b_mready = '0; b_mdata = '0;
    test_reset();
    test_single_fetch();
    test_in_order();
    test_two_channels();
    test_rerequest();
    test_reset_mid_wait();
    test_spurious_ready();
    test_random_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/program_mem_controller.md
Name: program_mem_controller

Overview:
- Responder end of the core fetchers' program-memory read interface (valid/address out, ready/data in).
- Accepts read requests from NUM_CONSUMERS fetchers and multiplexes them onto NUM_CHANNELS external program-memory read channels.
- Returns each instruction word to the requesting fetcher.
- Sits between all cores' fetchers and the external program memory. Read-only: program memory is never written by the GPU.

Parameters:
- ADDR_BITS, 8, program memory address width
- DATA_BITS, 16, instruction word width
- NUM_CONSUMERS, 4, number of fetchers served (1..16)
- NUM_CHANNELS, 1, number of concurrent external read channels (1..NUM_CONSUMERS)

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- consumer_read_valid  in  [NUM_CONSUMERS]  fetcher request; held until ready seen
- consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  request address; stable while valid
- consumer_read_ready  out  [NUM_CONSUMERS]  response valid for that fetcher
- consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  instruction word; valid while ready high
- mem_read_valid  out  [NUM_CHANNELS]  external read request
- mem_read_address  out  [NUM_CHANNELS][ADDR_BITS]  external read address
- mem_read_ready  in  [NUM_CHANNELS]  external response strobe
- mem_read_data  in  [NUM_CHANNELS][DATA_BITS]  external response data, sampled when ready

Behaviour:
- Reset:
  - All outputs go to 0.
  - Every channel goes to IDLE.
  - The claim mask clears (one bit per consumer; set = being served).
  - Reset takes effect on any cycle, including mid-transaction. An in-flight external response arriving after reset is ignored.
- Per-channel FSM, registered outputs. States: IDLE, WAITING, RELAYING.
- IDLE:
  - Candidate set = consumer_read_valid & ~claim.
  - If the set is non-empty, pick the lowest-index candidate c.
  - Record c as the channel's owner and set claim[c].
  - Drive mem_read_valid=1 and mem_read_address=consumer_read_address[c]. Go to WAITING.
- Intra-cycle allocation:
  - Channels are evaluated in ascending index.
  - A consumer picked by a lower channel this cycle is excluded from higher channels' candidate sets.
  - No consumer is ever served by two channels.
- WAITING:
  - On mem_read_ready: capture mem_read_data into consumer_read_data[owner], set consumer_read_ready[owner]=1, set mem_read_valid=0. Go to RELAYING.
  - mem_read_address holds its value while WAITING.
- RELAYING:
  - consumer_read_ready[owner] holds high until consumer_read_valid[owner] is seen low.
  - On that cycle: ready goes 0, claim[owner] clears, go to IDLE.
  - The freed consumer becomes eligible again the next cycle.
- Latency:
  - Request visible at cycle t → mem_read_valid high at t+1.
  - mem_read_ready at cycle u → consumer_read_ready high at u+1.
  - Minimum round trip is 2 cycles plus memory latency.
- Consumer rules:
  - consumer_read_data holds its last value after ready drops.
  - Ready never rises for a consumer without a prior claim.
- Boundary cases:
  - mem_read_ready while a channel is IDLE or RELAYING is ignored.
  - A consumer dropping valid while its channel is WAITING is a protocol violation. The channel still completes, then releases in RELAYING.
  - All channels busy → new requests wait, with no loss and no reordering of a pending request.
  - Request and release on the same consumer in the same cycle: the release wins; the new request is claimed no earlier than the next cycle.
- Width rules: addresses and data pass through unmodified; there is no arithmetic.

Decomposition:
- Package program_mem_pkg holds:
  - the channel-state enum (IDLE=2'b00, WAITING=2'b01, RELAYING=2'b10)
  - owner-index width $clog2(NUM_CONSUMERS), with a minimum of 1
- One sub-module: mem_req_picker. Combinational lowest-index-set-bit finder returning found and index. Instanced once per channel with that channel's masked candidate vector.

Test Plan:
- Single fetcher, 1 channel, memory latency 3, consumer 0 requests addr 0x05 → mem_read_valid=1 with address 0x05 one cycle later; data 0xA1B2 returned, consumer_read_ready[0] rises the cycle after mem_read_ready; ready drops the cycle after valid drops.
- 4 fetchers request simultaneously, 1 channel, addrs 0x10..0x13 → served strictly in order 0,1,2,3, each returning its own word; no two ready bits high at once.
- 4 fetchers, 2 channels, simultaneous requests → channel 0 serves consumer 0 and channel 1 serves consumer 1 in the same cycle; consumers 2 and 3 follow as channels free.
- Consumer 2 re-requests on the cycle its claim releases → re-claimed exactly one cycle later, never double-served.
- Reset asserted while WAITING, with a late mem_read_ready after reset → all outputs 0, no consumer_read_ready asserted, claim mask empty.
- Spurious mem_read_ready on an idle channel → no output changes.
